lcd_frame_sequencer: RTL and testbench

- Owns a 2x16 character frame buffer and replays it to the 1602A LCD controller as INIT/CLEAR/WRITE commands, using the controller's op/en/ready handshake.
- Sits between application logic and the LCD controller, so application logic only writes characters and requests a refresh.
- Moves the cursor to line 2 by writing pad blanks through DDRAM 0x10-0x27. The controller has no set-address op.

---
 rtl/lcd_frame_sequencer_if.sv | 13 +
 rtl/lcd_frame_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_frame_sequencer_if.sv
// Command bus between the frame sequencer (master) and the 1602A LCD controller (slave).
interface lcd_frame_sequencer_if;
    // Handshake: the master waits for ctrl_rdy=1, then pulses ctrl_en for one clk with
    // ctrl_op/ctrl_data valid; the slave drops ctrl_rdy while executing and raises it
    // again on completion. ctrl_op/ctrl_data stay stable until ctrl_rdy returns high.
    logic [1:0] ctrl_op;
    logic [7:0] ctrl_data;
    logic       ctrl_en;
    logic       ctrl_rdy;

    modport master (output ctrl_op, output ctrl_data, output ctrl_en, input ctrl_rdy);
    modport slave  (input ctrl_op, input ctrl_data, input ctrl_en, output ctrl_rdy);
endinterface

// File: rtl/lcd_frame_sequencer.sv
// Holds a 2x16 character frame and replays it to the LCD controller as CLEAR + WRITE commands.
// Optional feature macro: LCD_FRAME_DIRTY_EN (skip refreshes when nothing was written).
module lcd_frame_sequencer #(
    parameter int         LINE_LEN = 16,
    parameter int         PAD_LEN  = 24,
    parameter logic [7:0] BLANK    = 8'h20,
    parameter int         TIMEOUT  = 1000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [4:0]                   wr_addr,
    input  logic [7:0]                   wr_data,
    input  logic                         refresh_req,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    lcd_frame_sequencer_if.master        ctrl,
    output logic [3:0]                   dbg_state
);
    localparam int DEPTH     = 2 * LINE_LEN;
    localparam int NUM_ITEMS = 1 + DEPTH + PAD_LEN;
    localparam int KW        = $clog2(NUM_ITEMS);

    localparam logic [KW-1:0] K_LAST     = KW'(NUM_ITEMS - 1);
    localparam logic [KW-1:0] K_L1_END   = KW'(LINE_LEN);
    localparam logic [KW-1:0] K_L2_FIRST = KW'(1 + LINE_LEN + PAD_LEN);
    localparam logic [KW-1:0] L2_OFS     = KW'(1 + PAD_LEN);
    localparam logic [19:0]   TMO_LAST   = 20'(TIMEOUT - 1);
    localparam logic [4:0]    FILL_LAST  = 5'(DEPTH - 1);

    localparam logic [1:0] OP_INIT  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef enum logic [3:0] {
        S_FILL, S_INIT_ISSUE, S_INIT_ACK, S_INIT_DONE, S_IDLE,
        S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_NEXT, S_FAULT
    } state_t;

    state_t        state;
    logic [4:0]    fill_cnt;
    logic [KW-1:0] k;
    logic [19:0]   tmo_cnt;
    logic          pending;
    logic          en_q;
    logic [1:0]    op_q;
    logic [7:0]    data_q;
    logic [7:0]    buf_mem [DEPTH];
    logic [7:0]    item_char;
    logic          in_wait;
    logic          wait_met;
    logic          tmo_fault;
    logic          need_paint;
    logic          wr_accept;

    assign ctrl.ctrl_en   = en_q;
    assign ctrl.ctrl_op   = op_q;
    assign ctrl.ctrl_data = data_q;
    assign dbg_state      = state;
    assign busy           = (state != S_IDLE) && (state != S_FAULT);
    assign wr_accept      = wr_en && (state != S_FILL);

    // Line 2 starts at DDRAM 0x40, reached by writing PAD_LEN blanks after line 1.
    always_comb begin
        item_char = BLANK;
        if (k != '0 && k <= K_L1_END)
            item_char = buf_mem[5'(k - 1'b1)];
        else if (k >= K_L2_FIRST)
            item_char = buf_mem[5'(k - L2_OFS)];
    end

    always_comb begin
        in_wait  = 1'b0;
        wait_met = 1'b0;
        case (state)
            S_INIT_ACK, S_WAIT_ACK: begin
                in_wait  = 1'b1;
                wait_met = !ctrl.ctrl_rdy;
            end
            S_INIT_DONE, S_WAIT_DONE: begin
                in_wait  = 1'b1;
                wait_met = ctrl.ctrl_rdy;
            end
            default: ;
        endcase
    end

    assign tmo_fault = in_wait && !wait_met && (tmo_cnt == TMO_LAST);

`ifdef LCD_FRAME_DIRTY_EN
    logic dirty;
    always_ff @(posedge clk) begin
        if (rst)
            dirty <= 1'b1;
        else if (state == S_ISSUE && ctrl.ctrl_rdy && k == '0)
            dirty <= 1'b0;
        else if (wr_accept)
            dirty <= 1'b1;
    end
    assign need_paint = dirty;
`else
    assign need_paint = 1'b1;
`endif

    // Frame storage: reads are in the ISSUE clk, so a same-clk write is seen next time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_FILL)
                buf_mem[fill_cnt] <= BLANK;
            else if (wr_en)
                buf_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FILL;
            fill_cnt <= '0;
            k        <= '0;
            tmo_cnt  <= '0;
            pending  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            en_q     <= 1'b0;
            op_q     <= OP_INIT;
            data_q   <= '0;
        end else begin
            en_q    <= 1'b0;
            done    <= 1'b0;
            tmo_cnt <= tmo_cnt + 1'b1;
            if (refresh_req && state != S_IDLE && state != S_FAULT)
                pending <= 1'b1;

            if (tmo_fault) begin
                state  <= S_FAULT;
                err    <= 1'b1;
                op_q   <= OP_INIT;
                data_q <= '0;
            end else begin
                case (state)
                    S_FILL: begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == FILL_LAST) begin
                            state   <= S_INIT_ISSUE;
                            tmo_cnt <= '0;
                        end
                    end
                    S_INIT_ISSUE: if (ctrl.ctrl_rdy) begin
                        en_q    <= 1'b1;
                        op_q    <= OP_INIT;
                        data_q  <= '0;
                        state   <= S_INIT_ACK;
                        tmo_cnt <= '0;
                    end
                    S_INIT_ACK: if (wait_met) begin
                        state   <= S_INIT_DONE;
                        tmo_cnt <= '0;
                    end
                    S_INIT_DONE: if (wait_met) begin
                        tmo_cnt <= '0;
                        k       <= '0;
                        // A request that arrived during init is served straight away.
                        if (pending || refresh_req) begin
                            pending <= 1'b0;
                            state   <= S_ISSUE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_IDLE: if (refresh_req) begin
                        if (need_paint) begin
                            k       <= '0;
                            state   <= S_ISSUE;
                            tmo_cnt <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    S_ISSUE: if (ctrl.ctrl_rdy) begin
                        en_q    <= 1'b1;
                        op_q    <= (k == '0) ? OP_CLEAR : OP_WRITE;
                        data_q  <= (k == '0) ? 8'h00 : item_char;
                        state   <= S_WAIT_ACK;
                        tmo_cnt <= '0;
                    end
                    S_WAIT_ACK: if (wait_met) begin
                        state   <= S_WAIT_DONE;
                        tmo_cnt <= '0;
                    end
                    S_WAIT_DONE: if (wait_met) begin
                        op_q    <= OP_INIT;
                        data_q  <= '0;
                        state   <= S_NEXT;
                        tmo_cnt <= '0;
                    end
                    S_NEXT: begin
                        tmo_cnt <= '0;
                        if (k == K_LAST) begin
                            done <= 1'b1;
                            k    <= '0;
                            if (pending || refresh_req) begin
                                pending <= 1'b0;
                                state   <= S_ISSUE;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            k     <= k + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                    S_FAULT: ;
                    default: state <= S_FILL;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Randomized bench for lcd_frame_sequencer with a behavioural LCD controller and frame model.
module tb_lcd_frame_sequencer;
    localparam int TMO = 400;
    localparam logic [1:0] OP_INIT  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       refresh_req = 1'b0;
    logic       busy, done, err;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    lcd_frame_sequencer_if ctrl_bus ();

    lcd_frame_sequencer #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .refresh_req (refresh_req),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .ctrl        (ctrl_bus),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // LCD controller model: drops rdy for a few clks after each accepted command
    logic ctl_rdy = 1'b1;
    int   ctl_cnt = 0;
    bit   stuck = 1'b0;
    bit   rand_dly = 1'b0;
    assign ctrl_bus.ctrl_rdy = ctl_rdy;

    always @(posedge clk) begin
        if (ctrl_bus.ctrl_en && !stuck) begin
            ctl_rdy <= 1'b0;
            ctl_cnt <= rand_dly ? int'($urandom_range(6, 1)) : 5;
        end else if (ctl_cnt > 0) begin
            ctl_cnt <= ctl_cnt - 1;
            if (ctl_cnt == 1) ctl_rdy <= 1'b1;
        end
    end

    // scoreboard
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic [7:0] model_buf [32];
    int         done_cnt = 0;
    logic       prev_en = 1'b0;

    always @(negedge clk) begin
        if (ctrl_bus.ctrl_en) begin
            check("en_one_clk", prev_en, 1'b0);
            got_q.push_back({ctrl_bus.ctrl_op, ctrl_bus.ctrl_data});
        end
        if (done) done_cnt++;
        prev_en = ctrl_bus.ctrl_en;
    end

    // Expected frame replay: CLEAR, line 1, 24 pad blanks, line 2.
    task automatic build_exp();
        exp_q.push_back({OP_CLEAR, 8'h00});
        for (int i = 0; i < 16; i++) exp_q.push_back({OP_WRITE, model_buf[i]});
        for (int i = 0; i < 24; i++) exp_q.push_back({OP_WRITE, 8'h20});
        for (int i = 16; i < 32; i++) exp_q.push_back({OP_WRITE, model_buf[i]});
    endtask

    task automatic compare_seq(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // driver tasks
    task automatic write_char(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_buf[a] = d;
    endtask

    task automatic write_random(input int n);
        for (int i = 0; i < n; i++)
            write_char(5'($urandom_range(31, 0)), 8'($urandom_range(8'h7e, 8'h21)));
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        int cyc = 0;
        while (done_cnt < target && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check(tag, done_cnt, target);
    endtask

    task automatic wait_got(input int n);
        int cyc = 0;
        while (got_q.size() < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_en_count", got_q.size() >= n, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (busy && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, busy, 1'b0);
    endtask

    // Counts clks from reset release to the INIT strobe; optionally pokes a write mid-fill.
    task automatic measure_init(input bit poke);
        int cnt = 0;
        while (cnt < 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (poke) begin
                wr_en = (cnt == 2); wr_addr = 5'd10; wr_data = 8'h41;
            end
            if (ctrl_bus.ctrl_en) break;
        end
        wr_en = 1'b0;
        check("init_latency", cnt, 33);
        check("init_op", ctrl_bus.ctrl_op, OP_INIT);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] hello [5];
        logic [7:0] world [5];
        int base;
        hello = '{8'h48, 8'h45, 8'h4c, 8'h4c, 8'h4f};
        world = '{8'h57, 8'h4f, 8'h52, 8'h4c, 8'h44};
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_en", ctrl_bus.ctrl_en, 1'b0);
        check("rst_op", ctrl_bus.ctrl_op, 2'd0);
        check("rst_data", ctrl_bus.ctrl_data, 8'h00);
        rst = 1'b0;
        measure_init(1'b1);
        wait_idle("init_idle");
        exp_q.push_back({OP_INIT, 8'h00});
        compare_seq("init_seq");
        check("init_no_done", done_cnt, 0);

        // HELLO / WORLD frame, with the IDLE-to-CLEAR latency
        for (int i = 0; i < 5; i++) write_char(5'(i), hello[i]);
        for (int i = 0; i < 5; i++) write_char(5'(16 + i), world[i]);
        pulse_refresh();
        @(negedge clk);
        check("lat_en", ctrl_bus.ctrl_en, 1'b1);
        check("lat_op", ctrl_bus.ctrl_op, OP_CLEAR);
        build_exp();
        wait_done("hello_done", 1);
        compare_seq("hello");
        check("hello_idle", busy, 1'b0);

        // random frames with random controller latency
        rand_dly = 1'b1;
        for (int it = 0; it < 4; it++) begin
            write_random(int'($urandom_range(8, 1)));
            base = done_cnt;
            pulse_refresh();
            build_exp();
            wait_done("rand_done", base + 1);
            compare_seq("rand_seq");
        end

        // back-to-back refreshes without writes in between
        write_random(1);
        base = done_cnt;
        pulse_refresh();
        build_exp();
        wait_done("b2b_first", base + 1);
        compare_seq("b2b_first_seq");
        pulse_refresh();
`ifdef LCD_FRAME_DIRTY_EN
        check("clean_done_pulse", done, 1'b1);
        repeat (20) @(negedge clk);
        check("clean_no_en", got_q.size(), 0);
        check("clean_done_cnt", done_cnt, base + 2);
        got_q.delete();
`else
        build_exp();
        wait_done("b2b_second", base + 2);
        compare_seq("b2b_second_seq");
`endif

        // three requests mid-sequence merge into one extra pass
        write_random(2);
        base = done_cnt;
        pulse_refresh();
        wait_got(10);
        pulse_refresh();
        wait_got(30);
        pulse_refresh();
        wait_got(50);
        pulse_refresh();
        build_exp();
        build_exp();
        wait_done("pend_done", base + 2);
        repeat (100) @(negedge clk);
        check("pend_done_total", done_cnt, base + 2);
        compare_seq("pend_seq");

        // reset at k=30 aborts the refresh and reruns fill + init
        write_random(3);
        base = done_cnt;
        pulse_refresh();
        wait_got(31);
        rst = 1'b1;
        @(negedge clk);
        got_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
        measure_init(1'b0);
        wait_idle("rst2_idle");
        exp_q.push_back({OP_INIT, 8'h00});
        compare_seq("rst2_init_seq");
        check("rst2_no_done", done_cnt, base);
        pulse_refresh();
        build_exp();
        wait_done("rst2_blank_done", base + 1);
        compare_seq("rst2_blank_seq");

        // controller never acknowledges: timeout, then FAULT is terminal
        write_random(1);
        stuck = 1'b1;
        pulse_refresh();
        wait_got(1);
        repeat (TMO - 10) @(negedge clk);
        check("tmo_err_early", err, 1'b0);
        repeat (20) @(negedge clk);
        check("tmo_err", err, 1'b1);
        check("tmo_busy", busy, 1'b0);
        base = done_cnt;
        got_q.delete();
        pulse_refresh();
        repeat (50) @(negedge clk);
        check("fault_no_en", got_q.size(), 0);
        check("fault_no_done", done_cnt, base);
        check("fault_err_sticky", err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
